// File: rtl/retire_store_dmem_ctrl.sv
// retire_store_dmem_ctrl
//   Sits between the retire stage and the single data-memory port. Retired
//   stores go into an in-order circular store buffer and drain to Dmem. The
//   port is shared with at most one outstanding load from the load unit.
//   A load that aliases a buffered store (same 8-byte block) is held off until
//   the matching stores have been accepted. A drain-on-halt handshake is
//   provided through drain_req/drained.
//
// Build option:
//   SB_FWD_EN  - when defined, a load whose youngest aliasing entry has the
//                same addr and size is forwarded from the buffer (no Dmem
//                access). When undefined every alias blocks.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   st_valid/addr/data/size   retired store push
//   sb_full, sb_empty   buffer occupancy flags
//   ld_req/addr/size    load request (held until ld_grant)
//   ld_grant            load accepted (Dmem or forward) this cycle
//   ld_done, ld_data    one-cycle pulse with raw 64-bit load data
//   drain_req, drained  halt handshake: drain stores, no new loads
//   proc2Dmem_*         command/addr/data/size to Dmem
//   Dmem2proc_*         response tag, return data, return tag
module retire_store_dmem_ctrl #(
  parameter  int unsigned SB_DEPTH   = 4,
  localparam int unsigned XLEN       = 32,
  localparam int unsigned MEM_SIZE_W = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  st_valid,
  input  logic [XLEN-1:0]       st_addr,
  input  logic [XLEN-1:0]       st_data,
  input  logic [MEM_SIZE_W-1:0] st_size,
  output logic                  sb_full,
  output logic                  sb_empty,
  input  logic                  ld_req,
  input  logic [XLEN-1:0]       ld_addr,
  input  logic [MEM_SIZE_W-1:0] ld_size,
  output logic                  ld_grant,
  output logic                  ld_done,
  output logic [63:0]           ld_data,
  input  logic                  drain_req,
  output logic                  drained,
  output logic [1:0]            proc2Dmem_command,
  output logic [XLEN-1:0]       proc2Dmem_addr,
  output logic [63:0]           proc2Dmem_data,
  output logic [MEM_SIZE_W-1:0] proc2Dmem_size,
  input  logic [3:0]            Dmem2proc_response,
  input  logic [63:0]           Dmem2proc_data,
  input  logic [3:0]            Dmem2proc_tag
);

  localparam int unsigned PW = $clog2(SB_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

`ifdef SB_FWD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LD_WAIT = 2'd1, LD_FWD = 2'd2} state_e;
`else
  typedef enum logic {IDLE = 1'b0, LD_WAIT = 1'b1} state_e;
`endif

  state_e                r_state;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic [3:0]            r_saved_tag;
  logic                  r_ld_done;
  logic [63:0]           r_ld_data;
  logic                  r_drained;
  logic [XLEN-1:0]       r_sb_addr [SB_DEPTH];
  logic [XLEN-1:0]       r_sb_data [SB_DEPTH];
  logic [MEM_SIZE_W-1:0] r_sb_size [SB_DEPTH];

  logic w_full;
  logic w_empty;
  logic w_resp;
  logic w_alias;
  logic w_ld_ok;
  logic w_ld_issue;
  logic w_st_issue;
  logic w_push;
  logic w_pop;
  logic w_tag_hit;
`ifdef SB_FWD_EN
  logic          w_fwd;
  logic [PW-1:0] w_young;
`endif

  assign w_full   = (r_count == CW'(SB_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_resp   = (Dmem2proc_response != 4'd0);
  assign sb_full  = w_full;
  assign sb_empty = w_empty;
  assign ld_done  = r_ld_done;
  assign ld_data  = r_ld_data;
  assign drained  = r_drained;

  // Walk the valid entries oldest to youngest; the last hit is the youngest
  // aliasing store, which is the one forwarding must source from.
  always_comb begin : p_alias
    logic [PW-1:0] v_idx;
    v_idx   = '0;
    w_alias = 1'b0;
`ifdef SB_FWD_EN
    w_young = '0;
`endif
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      v_idx = r_head + PW'(k);
      if ((CW'(k) < r_count) &&
          (r_sb_addr[v_idx][XLEN-1:3] == ld_addr[XLEN-1:3])) begin
        w_alias = 1'b1;
`ifdef SB_FWD_EN
        w_young = v_idx;
`endif
      end
    end
  end

  // Full buffer or a pending halt gives stores the port; otherwise an
  // unaliased load wins, and the head store takes any idle slot.
  always_comb begin : p_issue
    w_ld_ok    = (r_state == IDLE) && ld_req && !drain_req && !w_full;
    w_ld_issue = w_ld_ok && !w_alias;
`ifdef SB_FWD_EN
    w_fwd      = w_ld_ok && w_alias &&
                 (r_sb_addr[w_young] == ld_addr) &&
                 (r_sb_size[w_young] == ld_size);
    w_st_issue = !w_empty && !w_ld_issue && !w_fwd;
    ld_grant   = (w_ld_issue && w_resp) || w_fwd;
`else
    w_st_issue = !w_empty && !w_ld_issue;
    ld_grant   = w_ld_issue && w_resp;
`endif
    proc2Dmem_command = BUS_NONE;
    proc2Dmem_addr    = '0;
    proc2Dmem_data    = '0;
    proc2Dmem_size    = '0;
    if (w_ld_issue) begin
      proc2Dmem_command = BUS_LOAD;
      proc2Dmem_addr    = ld_addr;
      proc2Dmem_size    = ld_size;
    end else if (w_st_issue) begin
      proc2Dmem_command = BUS_STORE;
      proc2Dmem_addr    = r_sb_addr[r_head];
      proc2Dmem_data    = {{(64-XLEN){1'b0}}, r_sb_data[r_head]};
      proc2Dmem_size    = r_sb_size[r_head];
    end
  end

  assign w_push    = st_valid && !w_full;
  assign w_pop     = w_st_issue && w_resp;
  assign w_tag_hit = (r_state == LD_WAIT) && (Dmem2proc_tag != 4'd0) &&
                     (Dmem2proc_tag == r_saved_tag);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_saved_tag <= '0;
      r_ld_done   <= 1'b0;
      r_ld_data   <= '0;
      r_drained   <= 1'b1;
    end else begin
      r_ld_done <= 1'b0;
      r_drained <= w_empty && (r_state == IDLE);

      if (w_push) begin
        r_sb_addr[r_tail] <= st_addr;
        r_sb_data[r_tail] <= st_data;
        r_sb_size[r_tail] <= st_size;
        r_tail            <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      case (r_state)
        IDLE: begin
          if (w_ld_issue && w_resp) begin
            r_saved_tag <= Dmem2proc_response;
            r_state     <= LD_WAIT;
          end
`ifdef SB_FWD_EN
          else if (w_fwd) begin
            r_ld_data <= {{(64-XLEN){1'b0}}, r_sb_data[w_young]};
            r_ld_done <= 1'b1;
            r_state   <= LD_FWD;
          end
`endif
        end
        LD_WAIT: begin
          if (w_tag_hit) begin
            r_ld_data <= Dmem2proc_data;
            r_ld_done <= 1'b1;
            r_state   <= IDLE;
          end
        end
`ifdef SB_FWD_EN
        LD_FWD:  r_state <= IDLE;
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_retire_store_dmem_ctrl.sv
module tb_retire_store_dmem_ctrl;

  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;
  localparam logic [1:0] BYTE  = 2'd0;
  localparam logic [1:0] WORD  = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        sb_full;
  logic        sb_empty;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_grant;
  logic        ld_done;
  logic [63:0] ld_data;
  logic        drain_req;
  logic        drained;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [63:0] proc2Dmem_data;
  logic [1:0]  proc2Dmem_size;
  logic [3:0]  Dmem2proc_response;
  logic [63:0] Dmem2proc_data;
  logic [3:0]  Dmem2proc_tag;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  retire_store_dmem_ctrl #(.SB_DEPTH(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .st_valid           (st_valid),
    .st_addr            (st_addr),
    .st_data            (st_data),
    .st_size            (st_size),
    .sb_full            (sb_full),
    .sb_empty           (sb_empty),
    .ld_req             (ld_req),
    .ld_addr            (ld_addr),
    .ld_size            (ld_size),
    .ld_grant           (ld_grant),
    .ld_done            (ld_done),
    .ld_data            (ld_data),
    .drain_req          (drain_req),
    .drained            (drained),
    .proc2Dmem_command  (proc2Dmem_command),
    .proc2Dmem_addr     (proc2Dmem_addr),
    .proc2Dmem_data     (proc2Dmem_data),
    .proc2Dmem_size     (proc2Dmem_size),
    .Dmem2proc_response (Dmem2proc_response),
    .Dmem2proc_data     (Dmem2proc_data),
    .Dmem2proc_tag      (Dmem2proc_tag)
  );

  // Pushing into a full buffer is illegal for the retire stage.
  always @(posedge clock) begin
    assert (reset !== 1'b0 || !(st_valid && sb_full)) else begin
      errors++;
      $display("FAIL push_while_full: st_valid=1 while sb_full=1");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = WORD;
    ld_req = 1'b0; ld_addr = '0; ld_size = WORD; drain_req = 1'b0;
    Dmem2proc_response = '0; Dmem2proc_data = '0; Dmem2proc_tag = '0;
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        stv;
    logic [31:0] sta;
    logic        ldr;
    logic [31:0] lda;
    logic        drn;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [63:0] rdata;
    logic        full;
    logic        empty;
    logic        grant;
    logic        done;
    logic        drained;
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] ldata;
  } vec_t;

  function automatic vec_t mk(
    input logic stv, input logic [31:0] sta, input logic ldr, input logic [31:0] lda,
    input logic drn, input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] rdata,
    input logic full, input logic empty, input logic grant, input logic done,
    input logic drn_o, input logic [1:0] cmd, input logic [31:0] addr, input logic [63:0] ldata);
    vec_t t;
    t.stv = stv; t.sta = sta; t.ldr = ldr; t.lda = lda; t.drn = drn;
    t.resp = resp; t.tag = tag; t.rdata = rdata;
    t.full = full; t.empty = empty; t.grant = grant; t.done = done;
    t.drained = drn_o; t.cmd = cmd; t.addr = addr; t.ldata = ldata;
    return t;
  endfunction

  // Store data in the table is derived from the store address so the
  // expected proc2Dmem_data follows from the expected address.
  task automatic apply(input vec_t t, input int idx);
    idle_in();
    st_valid = t.stv; st_addr = t.sta; st_data = {8'hF0, t.sta[23:0]};
    ld_req = t.ldr; ld_addr = t.lda; drain_req = t.drn;
    Dmem2proc_response = t.resp; Dmem2proc_tag = t.tag; Dmem2proc_data = t.rdata;
    #4;
    chk($sformatf("v%0d sb_full", idx),  64'(sb_full),  64'(t.full));
    chk($sformatf("v%0d sb_empty", idx), 64'(sb_empty), 64'(t.empty));
    chk($sformatf("v%0d ld_grant", idx), 64'(ld_grant), 64'(t.grant));
    chk($sformatf("v%0d ld_done", idx),  64'(ld_done),  64'(t.done));
    chk($sformatf("v%0d drained", idx),  64'(drained),  64'(t.drained));
    chk($sformatf("v%0d command", idx),  64'(proc2Dmem_command), 64'(t.cmd));
    if (t.cmd != NONE) begin
      chk($sformatf("v%0d addr", idx), 64'(proc2Dmem_addr), 64'(t.addr));
      chk($sformatf("v%0d size", idx), 64'(proc2Dmem_size), 64'(WORD));
      if (t.cmd == STORE)
        chk($sformatf("v%0d st_data", idx), proc2Dmem_data, {32'h0, 8'hF0, t.addr[23:0]});
    end
    if (t.done) chk($sformatf("v%0d ld_data", idx), ld_data, t.ldata);
    nxt();
  endtask

  vec_t tbl[$];

  initial begin
    // Fill: fill-to-full then drain in order, then drain_req with a pending load.
    //                  stv sta       ldr lda       drn resp tag rdata          full emp gnt dn drd cmd    addr      ldata
    tbl.push_back(mk(0, 32'h0,    0, 32'h0,    0, 0, 0, 64'h0,              0, 1, 0, 0, 1, NONE,  32'h0,    64'h0));
    tbl.push_back(mk(1, 32'h1000, 0, 32'h0,    0, 0, 0, 64'h0,              0, 1, 0, 0, 1, NONE,  32'h0,    64'h0));
    tbl.push_back(mk(1, 32'h1008, 0, 32'h0,    0, 0, 0, 64'h0,              0, 0, 0, 0, 1, STORE, 32'h1000, 64'h0));
    tbl.push_back(mk(1, 32'h1010, 0, 32'h0,    0, 0, 0, 64'h0,              0, 0, 0, 0, 0, STORE, 32'h1000, 64'h0));
    tbl.push_back(mk(1, 32'h1018, 0, 32'h0,    0, 0, 0, 64'h0,              0, 0, 0, 0, 0, STORE, 32'h1000, 64'h0));
    tbl.push_back(mk(0, 32'h0,    0, 32'h0,    0, 0, 0, 64'h0,              1, 0, 0, 0, 0, STORE, 32'h1000, 64'h0));
    tbl.push_back(mk(0, 32'h0,    0, 32'h0,    0, 1, 0, 64'h0,              1, 0, 0, 0, 0, STORE, 32'h1000, 64'h0));
    tbl.push_back(mk(0, 32'h0,    0, 32'h0,    0, 1, 0, 64'h0,              0, 0, 0, 0, 0, STORE, 32'h1008, 64'h0));
    tbl.push_back(mk(0, 32'h0,    0, 32'h0,    0, 1, 0, 64'h0,              0, 0, 0, 0, 0, STORE, 32'h1010, 64'h0));
    tbl.push_back(mk(0, 32'h0,    0, 32'h0,    0, 1, 0, 64'h0,              0, 0, 0, 0, 0, STORE, 32'h1018, 64'h0));
    tbl.push_back(mk(0, 32'h0,    0, 32'h0,    0, 0, 0, 64'h0,              0, 1, 0, 0, 0, NONE,  32'h0,    64'h0));
    tbl.push_back(mk(0, 32'h0,    0, 32'h0,    0, 0, 0, 64'h0,              0, 1, 0, 0, 1, NONE,  32'h0,    64'h0));
    tbl.push_back(mk(1, 32'h2000, 0, 32'h0,    0, 0, 0, 64'h0,              0, 1, 0, 0, 1, NONE,  32'h0,    64'h0));
    tbl.push_back(mk(1, 32'h2008, 0, 32'h0,    0, 0, 0, 64'h0,              0, 0, 0, 0, 1, STORE, 32'h2000, 64'h0));
    tbl.push_back(mk(1, 32'h2010, 0, 32'h0,    0, 0, 0, 64'h0,              0, 0, 0, 0, 0, STORE, 32'h2000, 64'h0));
    tbl.push_back(mk(0, 32'h0,    1, 32'h3000, 1, 1, 0, 64'h0,              0, 0, 0, 0, 0, STORE, 32'h2000, 64'h0));
    tbl.push_back(mk(0, 32'h0,    1, 32'h3000, 1, 1, 0, 64'h0,              0, 0, 0, 0, 0, STORE, 32'h2008, 64'h0));
    tbl.push_back(mk(0, 32'h0,    1, 32'h3000, 1, 1, 0, 64'h0,              0, 0, 0, 0, 0, STORE, 32'h2010, 64'h0));
    tbl.push_back(mk(0, 32'h0,    1, 32'h3000, 1, 1, 0, 64'h0,              0, 1, 0, 0, 0, NONE,  32'h0,    64'h0));
    tbl.push_back(mk(0, 32'h0,    1, 32'h3000, 1, 1, 0, 64'h0,              0, 1, 0, 0, 1, NONE,  32'h0,    64'h0));
    tbl.push_back(mk(0, 32'h0,    1, 32'h3000, 0, 1, 0, 64'h0,              0, 1, 1, 0, 1, LOAD,  32'h3000, 64'h0));
    tbl.push_back(mk(0, 32'h0,    0, 32'h0,    0, 0, 1, 64'hCAFEF00D12345678, 0, 1, 0, 0, 1, NONE,  32'h0,    64'h0));
    tbl.push_back(mk(0, 32'h0,    0, 32'h0,    0, 0, 0, 64'h0,              0, 1, 0, 1, 0, NONE,  32'h0,    64'hCAFEF00D12345678));
    tbl.push_back(mk(0, 32'h0,    0, 32'h0,    0, 0, 0, 64'h0,              0, 1, 0, 0, 1, NONE,  32'h0,    64'h0));

    idle_in();
    reset = 1'b1;
    nxt(); nxt();
    reset = 1'b0;
    #4;
    chk("reset ld_data", ld_data, 64'h0);
    nxt();

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Aliasing load waits for the store to 0x100 to be accepted.
    idle_in(); st_valid = 1'b1; st_addr = 32'h100; st_data = 32'h55; nxt();
    idle_in(); ld_req = 1'b1; ld_addr = 32'h104; #4;
    chk("alias blocked grant", 64'(ld_grant), 64'd0);
    chk("alias blocked cmd", 64'(proc2Dmem_command), 64'(STORE));
    chk("alias blocked addr", 64'(proc2Dmem_addr), 64'h100);
    nxt();
    Dmem2proc_response = 4'd1; #4;
    chk("alias accept grant", 64'(ld_grant), 64'd0);
    chk("alias accept cmd", 64'(proc2Dmem_command), 64'(STORE));
    nxt();
    Dmem2proc_response = 4'd2; #4;
    chk("alias load cmd", 64'(proc2Dmem_command), 64'(LOAD));
    chk("alias load addr", 64'(proc2Dmem_addr), 64'h104);
    chk("alias load grant", 64'(ld_grant), 64'd1);
    nxt();
    idle_in(); #4;
    chk("alias wait cmd", 64'(proc2Dmem_command), 64'(NONE));
    nxt();
    Dmem2proc_tag = 4'd2; Dmem2proc_data = 64'h123456789ABCDEF0; #4;
    chk("alias tag cycle done", 64'(ld_done), 64'd0);
    nxt();
    idle_in(); #4;
    chk("alias done", 64'(ld_done), 64'd1);
    chk("alias ld_data", ld_data, 64'h123456789ABCDEF0);
    nxt();
    #4;
    chk("alias done pulse", 64'(ld_done), 64'd0);
    nxt();

    // Same addr/size load after a WORD store.
    idle_in(); st_valid = 1'b1; st_addr = 32'h200; st_data = 32'hDEADBEEF; nxt();
`ifdef SB_FWD_EN
    idle_in(); ld_req = 1'b1; ld_addr = 32'h200; #4;
    chk("fwd grant", 64'(ld_grant), 64'd1);
    chk("fwd no dmem load", 64'(proc2Dmem_command), 64'(NONE));
    nxt();
    idle_in(); #4;
    chk("fwd done", 64'(ld_done), 64'd1);
    chk("fwd ld_data", ld_data, 64'h00000000DEADBEEF);
    nxt();
    idle_in(); ld_req = 1'b1; ld_addr = 32'h200; ld_size = BYTE; #4;
    chk("fwd partial blocked", 64'(ld_grant), 64'd0);
    chk("fwd partial cmd", 64'(proc2Dmem_command), 64'(STORE));
    nxt();
    idle_in(); Dmem2proc_response = 4'd1; nxt();
    idle_in(); #4;
    chk("fwd drained empty", 64'(sb_empty), 64'd1);
    nxt();
`else
    idle_in(); ld_req = 1'b1; ld_addr = 32'h200; #4;
    chk("nofwd blocked grant", 64'(ld_grant), 64'd0);
    chk("nofwd store cmd", 64'(proc2Dmem_command), 64'(STORE));
    chk("nofwd store addr", 64'(proc2Dmem_addr), 64'h200);
    chk("nofwd store data", proc2Dmem_data, 64'h00000000DEADBEEF);
    nxt();
    Dmem2proc_response = 4'd1; nxt();
    Dmem2proc_response = 4'd4; #4;
    chk("nofwd load cmd", 64'(proc2Dmem_command), 64'(LOAD));
    chk("nofwd load grant", 64'(ld_grant), 64'd1);
    nxt();
    idle_in(); Dmem2proc_tag = 4'd4; Dmem2proc_data = 64'h77; nxt();
    idle_in(); #4;
    chk("nofwd done", 64'(ld_done), 64'd1);
    chk("nofwd ld_data", ld_data, 64'h77);
    nxt();
`endif

    // Outstanding load (tag 3) while two stores drain; wrong tag ignored.
    idle_in(); st_valid = 1'b1; st_addr = 32'h400; st_data = 32'h1; nxt();
    idle_in(); st_valid = 1'b1; st_addr = 32'h408; st_data = 32'h2;
    ld_req = 1'b1; ld_addr = 32'h500; Dmem2proc_response = 4'd3; #4;
    chk("tag load grant", 64'(ld_grant), 64'd1);
    chk("tag load cmd", 64'(proc2Dmem_command), 64'(LOAD));
    nxt();
    idle_in(); Dmem2proc_response = 4'd1; Dmem2proc_tag = 4'd5; Dmem2proc_data = 64'hBAD; #4;
    chk("wait store0 addr", 64'(proc2Dmem_addr), 64'h400);
    chk("wait store0 grant", 64'(ld_grant), 64'd0);
    nxt();
    Dmem2proc_tag = 4'd3; Dmem2proc_data = 64'h600D; #4;
    chk("wrong tag ignored", 64'(ld_done), 64'd0);
    chk("wait store1 cmd", 64'(proc2Dmem_command), 64'(STORE));
    chk("wait store1 addr", 64'(proc2Dmem_addr), 64'h408);
    nxt();
    idle_in(); #4;
    chk("tag3 done", 64'(ld_done), 64'd1);
    chk("tag3 ld_data", ld_data, 64'h600D);
    chk("tag3 both popped", 64'(sb_empty), 64'd1);
    nxt();
    #4;
    chk("tag3 done pulse", 64'(ld_done), 64'd0);
    nxt();

    // Reset while a load waits: buffered store and late tag are discarded.
    idle_in(); st_valid = 1'b1; st_addr = 32'h700;
    ld_req = 1'b1; ld_addr = 32'h500; Dmem2proc_response = 4'd3; #4;
    chk("pre-reset grant", 64'(ld_grant), 64'd1);
    nxt();
    idle_in(); reset = 1'b1; nxt();
    idle_in(); Dmem2proc_tag = 4'd3; Dmem2proc_data = 64'hBAD; #4;
    chk("post-reset empty", 64'(sb_empty), 64'd1);
    chk("post-reset drained", 64'(drained), 64'd1);
    chk("post-reset cmd", 64'(proc2Dmem_command), 64'(NONE));
    nxt();
    idle_in(); #4;
    chk("late tag no done", 64'(ld_done), 64'd0);
    chk("late tag ld_data", ld_data, 64'h0);
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/retire_store_dmem_ctrl.md
# retire_store_dmem_ctrl

- Sits between the retire stage and the single data-memory port.
- Buffers retired stores in an in-order store buffer and drains them to Dmem.
- Shares the Dmem port between draining stores and one outstanding load from the load unit.
- Blocks or forwards loads that alias buffered stores, and provides a drain-on-halt handshake.

## Interface
Parameters:
- `SB_DEPTH`, default 4: store-buffer entries; power of two, 2–16.

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `st_valid`  in  1  retired store this cycle; the retire stage drives `store2Dmem_command==BUS_STORE`
- `st_addr`  in  `XLEN`  store byte address
- `st_data`  in  `XLEN`  store data
- `st_size`  in  `MEM_SIZE`  BYTE/HALF/WORD
- `sb_full`  out  1  buffer holds `SB_DEPTH` entries; retire must stall stores
- `sb_empty`  out  1  buffer holds 0 entries
- `ld_req`  in  1  load request, held until `ld_grant`
- `ld_addr`  in  `XLEN`  load byte address
- `ld_size`  in  `MEM_SIZE`  load size
- `ld_grant`  out  1  load accepted (by Dmem or by forwarding) this cycle
- `ld_done`  out  1  single-cycle pulse; `ld_data` valid
- `ld_data`  out  64  load return data, raw 64-bit block
- `drain_req`  in  1  halt pending; stop issuing loads and drain all stores
- `drained`  out  1  buffer empty and no load outstanding
- `proc2Dmem_command`  out  2  BUS_NONE/BUS_LOAD/BUS_STORE
- `proc2Dmem_addr`  out  `XLEN`  memory address
- `proc2Dmem_data`  out  64  store data, zero-extended
- `proc2Dmem_size`  out  `MEM_SIZE`  access size
- `Dmem2proc_response`  in  4  nonzero = command accepted, value = tag
- `Dmem2proc_data`  in  64  returned data
- `Dmem2proc_tag`  in  4  nonzero = data for that tag is valid

## Operation
Store buffer:
- Circular FIFO with head/tail pointers and a count of `$clog2(SB_DEPTH)+1` bits.
- `st_valid` pushes at the tail.
- A store is popped from the head when it is the issued command and `Dmem2proc_response!=0`.
- Push and pop in the same cycle leave the count unchanged.
- `st_valid` while `sb_full` is illegal; it is ignored, and a bench assertion fires.

FSM:
- `IDLE`: no load outstanding.
  - Issue a load when `ld_req`, `!drain_req`, and the load is not blocked.
  - Otherwise issue the head store if the buffer is non-empty.
  - A load accepted by Dmem: capture the tag, go to `LD_WAIT`.
  - A forwarded load (see Configuration): go to `LD_FWD`.
- `LD_WAIT`: the head store may still issue. Loads are not issued.
  - When `Dmem2proc_tag==saved_tag`, register the data and go to `IDLE`.
- `LD_FWD`: lasts one cycle. Go to `IDLE`.

Load blocking:
- A load is blocked if `ld_addr[XLEN-1:3]` equals `addr[XLEN-1:3]` of any valid entry.
- While blocked, stores issue until no entry matches.

Arbitration priority in `IDLE`:
1. `sb_full` or `drain_req`: store first.
2. Otherwise an unblocked load.
3. Otherwise a store.

Outputs:
- `proc2Dmem_*` are combinational from the FSM state, the buffer head and the load inputs.
- `BUS_NONE` is driven when nothing issues.
- `ld_grant` is combinational and equals issue-and-accept (or a forward hit) in the cycle it happens.

Reset values:
- count, head, tail = 0; state = `IDLE`; `saved_tag` = 0.
- `sb_full`=0, `sb_empty`=1, `ld_grant`=0, `ld_done`=0, `ld_data`=0.
- `proc2Dmem_command`=BUS_NONE, `drained`=1.
- Reset mid-operation discards all buffered stores and any outstanding load. A late tag return is ignored.

## Timing
- Store push: visible in count, `sb_full` and `sb_empty` the cycle after `st_valid`.
- Store issue: earliest the cycle after push; popped at the edge where the response is nonzero.
- Load: `ld_grant` in the issue cycle; `ld_done` and `ld_data` one cycle after the matching tag appears. One outstanding load at most.
- Tag 0 is never a match.
- A tag arriving in the same cycle as a store issue is handled: both the pop and the load capture occur.
- `drained` is registered and updates one cycle after the buffer empties in `IDLE`.
- While `drain_req` is held, `ld_grant` stays 0.

## Configuration
- `SB_FWD_EN` defined, store-to-load forwarding is enabled:
  - Condition: the youngest matching entry has identical `addr` and `size` to the load.
  - Result: `ld_grant` in that cycle, no Dmem command, FSM goes to `LD_FWD`.
  - The next cycle gives `ld_done` with `ld_data = {32'b0, entry data}`.
  - Partial overlaps still block.
- `SB_FWD_EN` undefined: every alias blocks. `LD_FWD` is unreachable and compiled out.

## Test plan
- Reset, then idle: `sb_empty`=1, `drained`=1, command=BUS_NONE, `ld_done`=0.
- Push 4 stores with `SB_DEPTH`=4 and Dmem response held 0:
  - `sb_full`=1 on cycle 5.
  - Then set response=1: stores pop one per cycle in order, command=BUS_STORE, addresses match push order.
- Store to `0x100`, then load from `0x104` (same 8-byte block):
  - Load is blocked until the store is accepted.
  - Then the load issues with `BUS_LOAD`; response=2, tag=2 two cycles later, giving `ld_done` with the data the following cycle.
- With `SB_FWD_EN`, store WORD `0xDEADBEEF` @`0x200`, then load WORD @`0x200`:
  - `ld_grant` with no Dmem load; next cycle `ld_data`=`0x00000000DEADBEEF`.
- Load outstanding (tag 3) while two stores drain:
  - Wrong tag 5 is ignored; tag 3 gives `ld_done`.
  - Reset asserted mid-wait: the later tag 3 produces no `ld_done`.
- `drain_req` with 3 stores and `ld_req` high:
  - All stores issue, `ld_grant` stays 0, `drained`=1 one cycle after the last pop.
